lsu_wb_stage: RTL and testbench

- Pipeline stage directly downstream of the load/store unit. It captures the raw load doubleword and its access attributes, then selects the byte lane and sign- or zero-extends per access size.
- Forwards the result, or the ALU result for non-loads, to register-file writeback under a valid/ready handshake.
- Two-entry skid buffer gives full throughput with a registered in_ready. Flags misaligned or illegal-size loads and counts retired loads.

---
 rtl/lsu_wb_stage.sv | 268 ++++++++++++++++++++++++++
 tb/tb_lsu_wb_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb_stage.sv
// lsu_wb_stage: writeback stage directly after the load/store unit.
// Picks the addressed byte lane out of the raw load doubleword and sign- or
// zero-extends it by access size. Non-loads pass their ALU result through.
// Results sit in a two-entry skid buffer (main + skid) so the stage runs at
// full throughput while in_ready stays a plain flop output. Misaligned or
// illegal-size loads are flagged, and fault-free retired loads are counted.
//
// Handshake: an entry is accepted on a rising edge where in_valid & in_ready,
// and handed to writeback on a rising edge where out_valid & out_ready.
// While out_valid is high and out_ready is low, every out_* holds steady.
// Entries always leave in the order they arrived.

module lsu_wb_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_is_load,
  input  logic [XLEN-1:0]  in_addr,
  input  logic [3:0]       in_size,
  input  logic             in_signed,
  input  logic [XLEN-1:0]  in_rdata,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [4:0]       in_rd,
  input  logic             in_wen,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic [XLEN-1:0]  out_data,
  output logic             out_fault,
  output logic [CNT_W-1:0] load_count,
  output logic [1:0]       dbg_state
);

  // Buffer occupancy: EMPTY, ONE (main only) or FULL (main + skid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;

  // Handshake events and buffer control, derived from the state.
  logic accept;
  logic xfer;
  logic main_valid;
  logic skid_valid;
  logic main_ld;
  logic main_from_skid;
  logic skid_ld;
  logic cnt_inc;

  // Formatted view of the incoming entry.
  logic [XLEN-1:0] lane_sh;
  logic [XLEN-1:0] ext_data;
  logic            size_illegal;
  logic            misaligned;
  logic            fmt_fault;
  logic [XLEN-1:0] fmt_data;
  logic            fmt_wen;

  // Stored entries.
  logic [XLEN-1:0] main_pc_q, skid_pc_q;
  logic [4:0]      main_rd_q, skid_rd_q;
  logic            main_wen_q, skid_wen_q;
  logic [XLEN-1:0] main_data_q, skid_data_q;
  logic            main_fault_q, skid_fault_q;
  logic            main_load_q, skid_load_q;

  logic [CNT_W-1:0] load_count_q;

  // Only the low three address bits select a lane; upper bits are unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^in_addr[XLEN-1:3];

  // ---------------------------------------------------------------------
  // Input-side formatting
  // ---------------------------------------------------------------------

  assign lane_sh = in_rdata >> {in_addr[2:0], 3'b000};

  // Extend the selected lane by access size; size 8 ignores in_signed.
  always_comb begin
    ext_data     = lane_sh;
    size_illegal = 1'b0;
    misaligned   = 1'b0;
    case (in_size)
      4'd1: begin
        ext_data = {{(XLEN-8){in_signed & lane_sh[7]}}, lane_sh[7:0]};
      end
      4'd2: begin
        ext_data   = {{(XLEN-16){in_signed & lane_sh[15]}}, lane_sh[15:0]};
        misaligned = in_addr[0];
      end
      4'd4: begin
        ext_data   = {{(XLEN-32){in_signed & lane_sh[31]}}, lane_sh[31:0]};
        misaligned = |in_addr[1:0];
      end
      4'd8: begin
        ext_data   = lane_sh;
        misaligned = |in_addr[2:0];
      end
      default: begin
        ext_data     = lane_sh;
        size_illegal = 1'b1;
      end
    endcase
  end

  // Faulting loads write zero and never write the register file.
  always_comb begin
    fmt_fault = in_is_load & (size_illegal | misaligned);
    if (fmt_fault) begin
      fmt_data = '0;
    end else if (in_is_load) begin
      fmt_data = ext_data;
    end else begin
      fmt_data = in_alu_result;
    end
    fmt_wen = in_wen & (in_rd != 5'd0) & ~fmt_fault;
  end

  // ---------------------------------------------------------------------
  // Occupancy FSM
  // ---------------------------------------------------------------------

  // State register plus the registered in_ready (held low through reset).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next occupancy; flush empties the buffer regardless of handshakes.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !xfer)      state_d = ST_FULL;
          else if (!accept && xfer) state_d = ST_EMPTY;
        end
        ST_FULL:  if (xfer) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
    // in_ready next cycle is simply "skid will be free".
    in_ready_d = (state_d != ST_FULL);
  end

  // Per-state control: entry valids and which registers load this edge.
  always_comb begin
    main_valid     = (state_q != ST_EMPTY);
    skid_valid     = (state_q == ST_FULL);
    accept         = in_valid & in_ready_q;
    xfer           = main_valid & out_ready;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    cnt_inc        = 1'b0;
    if (!flush) begin
      cnt_inc = xfer & main_load_q & ~main_fault_q;
      case (state_q)
        ST_EMPTY: main_ld = accept;
        ST_ONE: begin
          main_ld = accept & xfer;
          skid_ld = accept & ~xfer;
        end
        ST_FULL: begin
          main_ld        = xfer;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Entry storage and retired-load counter
  // ---------------------------------------------------------------------

  // Main entry: loaded from the input, or refilled from skid when FULL drains.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_pc_q    <= '0;
      main_rd_q    <= '0;
      main_wen_q   <= 1'b0;
      main_data_q  <= '0;
      main_fault_q <= 1'b0;
      main_load_q  <= 1'b0;
    end else if (main_ld) begin
      if (main_from_skid) begin
        main_pc_q    <= skid_pc_q;
        main_rd_q    <= skid_rd_q;
        main_wen_q   <= skid_wen_q;
        main_data_q  <= skid_data_q;
        main_fault_q <= skid_fault_q;
        main_load_q  <= skid_load_q;
      end else begin
        main_pc_q    <= in_pc;
        main_rd_q    <= in_rd;
        main_wen_q   <= fmt_wen;
        main_data_q  <= fmt_data;
        main_fault_q <= fmt_fault;
        main_load_q  <= in_is_load;
      end
    end
  end

  // Skid entry: catches the new input when main is stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      skid_pc_q    <= '0;
      skid_rd_q    <= '0;
      skid_wen_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_fault_q <= 1'b0;
      skid_load_q  <= 1'b0;
    end else if (skid_ld) begin
      skid_pc_q    <= in_pc;
      skid_rd_q    <= in_rd;
      skid_wen_q   <= fmt_wen;
      skid_data_q  <= fmt_data;
      skid_fault_q <= fmt_fault;
      skid_load_q  <= in_is_load;
    end
  end

  // Count fault-free loads as they leave; wraps, and flush does not clear it.
  always_ff @(posedge clock) begin
    if (reset) begin
      load_count_q <= '0;
    end else if (cnt_inc) begin
      load_count_q <= load_count_q + 1'b1;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid;
  assign out_pc     = main_pc_q;
  assign out_rd     = main_rd_q;
  assign out_wen    = main_wen_q;
  assign out_data   = main_data_q;
  assign out_fault  = main_fault_q;
  assign load_count = load_count_q;
  assign dbg_state  = state_q;

  // skid_valid is implied by the state; kept for readability of the FSM.
  logic unused_skid_valid;
  assign unused_skid_valid = skid_valid;

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Directed bench for lsu_wb_stage: lane select / extension, faults,
// back-pressure through the skid buffer, flush and mid-stream reset.

module tb_lsu_wb_stage;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic        in_is_load;
  logic [63:0] in_addr;
  logic [3:0]  in_size;
  logic        in_signed;
  logic [63:0] in_rdata;
  logic [63:0] in_alu_result;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [63:0] out_data;
  logic        out_fault;
  logic [63:0] load_count;
  logic [1:0]  dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  lsu_wb_stage #(.XLEN(64), .CNT_W(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_is_load    (in_is_load),
    .in_addr       (in_addr),
    .in_size       (in_size),
    .in_signed     (in_signed),
    .in_rdata      (in_rdata),
    .in_alu_result (in_alu_result),
    .in_rd         (in_rd),
    .in_wen        (in_wen),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_rd        (out_rd),
    .out_wen       (out_wen),
    .out_data      (out_data),
    .out_fault     (out_fault),
    .load_count    (load_count),
    .dbg_state     (dbg_state)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Driver tasks
  task automatic drive_load(input logic [63:0] pc, input logic [63:0] addr,
                            input logic [3:0] size, input logic sgn,
                            input logic [63:0] rdata, input logic [4:0] rd,
                            input logic wen);
    in_valid      = 1'b1;
    in_pc         = pc;
    in_is_load    = 1'b1;
    in_addr       = addr;
    in_size       = size;
    in_signed     = sgn;
    in_rdata      = rdata;
    in_alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
    in_rd         = rd;
    in_wen        = wen;
  endtask

  task automatic drive_alu(input logic [63:0] pc, input logic [63:0] res,
                           input logic [4:0] rd, input logic wen);
    in_valid      = 1'b1;
    in_pc         = pc;
    in_is_load    = 1'b0;
    in_addr       = 64'h0000_0000_0000_0007;
    in_size       = 4'd3;
    in_signed     = 1'b1;
    in_rdata      = 64'hFFFF_FFFF_FFFF_FFFF;
    in_alu_result = res;
    in_rd         = rd;
    in_wen        = wen;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Comparison point
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_is_load = 1'b0; in_addr = '0; in_size = 4'd8;
    in_signed = 1'b0; in_rdata = '0; in_alu_result = '0; in_rd = '0; in_wen = 1'b0;

    // ---- reset ----
    tick(); tick();
    chk("rst_in_ready",   in_ready,   0);
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_out_data",   out_data,   0);
    chk("rst_load_count", load_count, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_state",    dbg_state, S_EMPTY);

    // ---- lb signed, byte lane 3 ----
    drive_load(64'h100, 64'h8000_0003, 4'd1, 1'b1, 64'h1122_3344_8566_7788, 5'd5, 1'b1);
    tick();
    idle();
    chk("lb_valid", out_valid, 1);
    chk("lb_data",  out_data,  64'hFFFF_FFFF_FFFF_FF85);
    chk("lb_wen",   out_wen,   1);
    chk("lb_fault", out_fault, 0);
    chk("lb_rd",    out_rd,    5);
    chk("lb_pc",    out_pc,    64'h100);
    chk("lb_cnt0",  load_count, 0);
    out_ready = 1'b1;
    tick();
    chk("lb_cnt1",    load_count, 1);
    chk("lb_drained", out_valid,  0);

    // ---- lhu then lw signed back-to-back (ONE + accept + transfer) ----
    drive_load(64'h104, 64'h8000_0006, 4'd2, 1'b0, 64'hBEEF_0000_0000_0000, 5'd6, 1'b1);
    tick();
    chk("lhu_data", out_data, 64'h0000_0000_0000_BEEF);
    drive_load(64'h108, 64'h8000_0004, 4'd4, 1'b1, 64'h8000_0001_0000_0000, 5'd7, 1'b1);
    tick();
    idle();
    chk("lw_data",  out_data,   64'hFFFF_FFFF_8000_0001);
    chk("lw_pc",    out_pc,     64'h108);
    chk("lw_state", dbg_state,  S_ONE);
    chk("lhu_cnt",  load_count, 2);
    tick();
    chk("lw_cnt",   load_count, 3);

    // ---- misaligned lw ----
    drive_load(64'h10C, 64'h8000_0002, 4'd4, 1'b1, 64'h1234_5678_9ABC_DEF0, 5'd8, 1'b1);
    tick();
    idle();
    chk("mis_fault", out_fault, 1);
    chk("mis_data",  out_data,  0);
    chk("mis_wen",   out_wen,   0);
    tick();
    chk("mis_cnt",   load_count, 3);

    // ---- illegal size 3 ----
    drive_load(64'h110, 64'h8000_0000, 4'd3, 1'b0, 64'h1234_5678_9ABC_DEF0, 5'd9, 1'b1);
    tick();
    idle();
    chk("sz3_fault", out_fault, 1);
    chk("sz3_data",  out_data,  0);
    tick();
    chk("sz3_cnt",   load_count, 3);

    // ---- non-load to x0 ----
    drive_alu(64'h114, 64'h1234, 5'd0, 1'b1);
    tick();
    idle();
    chk("alu_data",  out_data,  64'h1234);
    chk("alu_wen",   out_wen,   0);
    chk("alu_fault", out_fault, 0);
    tick();
    chk("alu_cnt",   load_count, 3);

    // ---- back-pressure: A, B, C with out_ready low ----
    out_ready = 1'b0;
    drive_load(64'h200, 64'h0, 4'd1, 1'b0, 64'h0000_0000_0000_00AA, 5'd1, 1'b1);  // A
    tick();
    chk("bp_a_ready", in_ready, 1);
    drive_alu(64'h204, 64'hB, 5'd2, 1'b1);                                        // B
    tick();
    chk("bp_full_ready", in_ready,  0);
    chk("bp_full_state", dbg_state, S_FULL);
    drive_alu(64'h208, 64'hC, 5'd3, 1'b1);                                        // C
    tick();
    chk("bp_hold_data",  out_data, 64'hAA);
    chk("bp_hold_pc",    out_pc,   64'h200);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_b_data", out_data,   64'hB);
    chk("bp_a_cnt",  load_count, 4);
    chk("bp_ready",  in_ready,   1);
    tick();
    idle();
    chk("bp_c_data",  out_data,  64'hC);
    chk("bp_c_valid", out_valid, 1);
    tick();
    chk("bp_empty", out_valid,  0);
    chk("bp_cnt",   load_count, 4);

    // ---- flush while FULL ----
    out_ready = 1'b0;
    drive_load(64'h300, 64'h0, 4'd1, 1'b0, 64'h11, 5'd4, 1'b1);
    tick();
    drive_load(64'h304, 64'h1, 4'd1, 1'b0, 64'h2200, 5'd4, 1'b1);
    tick();
    chk("fl_full", dbg_state, S_FULL);
    flush = 1'b1; out_ready = 1'b1;
    drive_load(64'h308, 64'h0, 4'd1, 1'b0, 64'h33, 5'd4, 1'b1);
    tick();
    flush = 1'b0;
    idle();
    chk("fl_valid", out_valid,  0);
    chk("fl_ready", in_ready,   1);
    chk("fl_cnt",   load_count, 4);
    tick();
    chk("fl_dropped", out_valid, 0);

    // ---- reset while FULL ----
    out_ready = 1'b0;
    drive_load(64'h400, 64'h0, 4'd8, 1'b0, 64'h0102_0304_0506_0708, 5'd10, 1'b1);
    tick();
    drive_alu(64'h404, 64'h55, 5'd11, 1'b1);
    tick();
    idle();
    chk("rs_full", dbg_state, S_FULL);
    chk("rs_d8",   out_data,  64'h0102_0304_0506_0708);
    reset = 1'b1;
    tick();
    chk("rs_valid", out_valid,  0);
    chk("rs_data",  out_data,   0);
    chk("rs_pc",    out_pc,     0);
    chk("rs_cnt",   load_count, 0);
    chk("rs_ready", in_ready,   0);
    reset = 1'b0;
    tick();
    chk("rs_ready_after", in_ready,  1);
    chk("rs_valid_after", out_valid, 0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
